jtag_tap_ctrl: RTL and testbench
================================

// Module: jtag_tap_ctrl
// PURPOSE
//  Parametrised IEEE 1149.1 TAP controller, slave side of jtag_if (tdi/tms in, tdo out).
//  Provides a 16-state TAP FSM, an IR_WIDTH instruction register, BYPASS and IDCODE,
//  and NUM_DR user data registers of DR_WIDTH, each with parallel capture/update ports.
//  Successor to the fixed single-chain slave; sits between the JTAG pins and on-die user logic.
// PARAMETERS
//  IR_WIDTH   4             instruction register length, >=2
//  DR_WIDTH   16            user data register length, >=1
//  NUM_DR     2             number of user data registers, 1..(2**IR_WIDTH-3)
//  IDCODE_VAL 32'h1000_0001 IDCODE value; bit0 must be 1
// PORTS
//  tck            in   1                 TAP clock; all state updates on posedge
//  trst           in   1                 synchronous, active-low reset
//  tms            in   1                 mode select, sampled on posedge tck
//  tdi            in   1                 serial data in, sampled on posedge tck
//  tdo            out  1                 serial data out
//  tdo_en         out  1                 1 while in SHIFT_DR or SHIFT_IR
//  ir_q           out  IR_WIDTH          current (updated) instruction
//  dr_cap_data    in   NUM_DR*DR_WIDTH   parallel values loaded at CAPTURE_DR; slot k = [k*DR_WIDTH +: DR_WIDTH]
//  dr_upd_data    out  NUM_DR*DR_WIDTH   held user DR values, changed only at UPDATE_DR
//  dr_upd_pulse   out  NUM_DR            1-cycle pulse on cycle after UPDATE_DR, selected DR only
// BEHAVIOUR
//  Reset (trst==0 at posedge): state=TEST_LOGIC_RESET, ir_q=IDCODE, all shift regs 0,
//   dr_upd_data=0, dr_upd_pulse=0, tdo_en=0. Reset wins over any tms value.
//  FSM: standard 16 states (TLR,RTI,SEL_DR,CAP_DR,SHIFT_DR,EXIT1_DR,PAUSE_DR,EXIT2_DR,
//   UPD_DR, and the IR mirror set); transition per tms each posedge. Five tms=1 cycles
//   from any state reach TLR. TLR behaves as reset for ir_q only (ir_q=IDCODE).
//  Instruction decode: all-ones=BYPASS; 1=IDCODE; 2+k=USER_k (k<NUM_DR); any other
//   code (including 0) decodes as BYPASS.
//  CAP_IR: ir_shift <= {zeros,2'b01}. SHIFT_IR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
//   UPD_IR: ir_q <= ir_shift. ir_q is never changed mid-shift.
//  CAP_DR by instruction: BYPASS bit<=0; IDCODE reg<=IDCODE_VAL; USER_k reg<=dr_cap_data[k].
//  SHIFT_DR: selected register shifts right LSB-first, tdi into MSB; BYPASS is 1 bit.
//  UPD_DR: for USER_k, dr_upd_data[k] <= shift reg; dr_upd_pulse[k]=1 on next cycle.
//   IDCODE/BYPASS updates have no effect.
//  tdo: combinational LSB of the selected shift register while tdo_en=1, else 0. Bits are
//   valid for master posedge sampling; the first bit is visible on entering SHIFT.
//  PAUSE states hold shift contents; EXIT2->SHIFT resumes without recapture.
//  trst asserted mid-shift aborts the shift: no update, dr_upd_data cleared to 0.
// STRUCTURE
//  Package jtag_pkg: tap_state_e enum (16 states, 4-bit), BYPASS/IDCODE opcode
//   functions of IR_WIDTH, and the IR capture constant 2'b01.
//  Sub-module jtag_tap_fsm: tck/trst/tms -> state plus one-hot capture/shift/update flags.
//   The top holds the IR, BYPASS, IDCODE and user shift registers and the tdo mux.
// TESTING
//  1. trst=0 for 2 cycles, then 5x tms=1 -> state=TLR, ir_q=4'h1, dr_upd_data=0.
//  2. After reset go to SHIFT_DR and shift 32 bits -> tdo yields 32'h1000_0001 LSB first.
//  3. Load IR=4'hF (BYPASS), shift 8'hA5 in DR -> tdo returns 8'hA5 delayed by 1 bit;
//     tdo in the first shift cycle = 0.
//  4. IR=4'h3 (USER_1), dr_cap_data[1]=16'hBEEF, shift in 16'h1234 -> tdo=16'hBEEF,
//     dr_upd_data[1]=16'h1234, dr_upd_pulse=2'b10 for exactly 1 cycle, slot 0 unchanged.
//  5. SHIFT_IR: tdo shows 2'b01 in the first two bits. Unused code 4'h9 decodes as BYPASS.
//  6. USER_0 shift with PAUSE_DR mid-way and 3 pause cycles -> result matches an
//     unpaused shift. Repeat with trst pulse mid-shift -> no dr_upd_pulse, outputs reset.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP types and constants: the 16-state TAP enumeration, IR opcode helpers and
// the fixed IR capture pattern.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_e;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

    function automatic logic [31:0] bypass_op(input int unsigned ir_width);
        return (32'd1 << ir_width) - 32'd1;
    endfunction

    function automatic logic [31:0] idcode_op(input int unsigned ir_width);
        return (ir_width >= 2) ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/jtag_if.sv
// Serial JTAG pin bundle: the master drives tms/tdi, the TAP slave returns tdo/tdo_en.
interface jtag_if;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;

    modport master (output tms, output tdi, input tdo, input tdo_en);
    modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine; the flags mark the state being left at the next tck edge,
// which is where the matching capture/shift/update action takes effect.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state,
    output logic       tlr,
    output logic       cap_dr,
    output logic       shift_dr,
    output logic       upd_dr,
    output logic       cap_ir,
    output logic       shift_ir,
    output logic       upd_ir
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge tck) begin
        if (!trst) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:      state_d = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   state_d = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      state_d = TAP_TLR;
        endcase
    end

    assign state    = state_q;
    assign tlr      = (state_q == TAP_TLR);
    assign cap_dr   = (state_q == TAP_CAP_DR);
    assign shift_dr = (state_q == TAP_SHIFT_DR);
    assign upd_dr   = (state_q == TAP_UPD_DR);
    assign cap_ir   = (state_q == TAP_CAP_IR);
    assign shift_ir = (state_q == TAP_SHIFT_IR);
    assign upd_ir   = (state_q == TAP_UPD_IR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction register, BYPASS/IDCODE and NUM_DR user data registers
// with parallel capture/update ports, plus the tdo multiplexer.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter int          DR_WIDTH   = 16,
    parameter int          NUM_DR     = 2,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                       tck,
    input  logic                       trst,
    jtag_if.slave                      jtag,
    output logic [IR_WIDTH-1:0]        ir_q,
    input  logic [NUM_DR*DR_WIDTH-1:0] dr_cap_data,
    output logic [NUM_DR*DR_WIDTH-1:0] dr_upd_data,
    output logic [NUM_DR-1:0]          dr_upd_pulse
);

    localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(bypass_op(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(idcode_op(IR_WIDTH));

    tap_state_e state;
    logic tlr, cap_dr, shift_dr, upd_dr, cap_ir, shift_ir, upd_ir;

    jtag_tap_fsm u_fsm (
        .tck      (tck),
        .trst     (trst),
        .tms      (jtag.tms),
        .state    (state),
        .tlr      (tlr),
        .cap_dr   (cap_dr),
        .shift_dr (shift_dr),
        .upd_dr   (upd_dr),
        .cap_ir   (cap_ir),
        .shift_ir (shift_ir),
        .upd_ir   (upd_ir)
    );

    // Anything not IDCODE or a valid USER code (all-ones, 0, spare codes) selects BYPASS.
    logic [NUM_DR-1:0] sel_user;
    logic              sel_idcode;
    logic              sel_bypass;
    logic [NUM_DR-1:0] user_lsb;

    assign sel_idcode = (ir_q == OP_IDCODE) && (ir_q != OP_BYPASS);
    assign sel_bypass = !sel_idcode && !(|sel_user);

    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d, ir_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_q, idcode_d;

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        bypass_d   = bypass_q;
        idcode_d   = idcode_q;
        if (cap_ir) begin
            ir_shift_d = IR_WIDTH'(IR_CAPTURE);
        end else if (shift_ir) begin
            ir_shift_d = {jtag.tdi, ir_shift_q[IR_WIDTH-1:1]};
        end
        if (tlr) begin
            ir_d = OP_IDCODE;
        end else if (upd_ir) begin
            ir_d = ir_shift_q;
        end
        if (sel_bypass && cap_dr) begin
            bypass_d = 1'b0;
        end else if (sel_bypass && shift_dr) begin
            bypass_d = jtag.tdi;
        end
        if (sel_idcode && cap_dr) begin
            idcode_d = IDCODE_VAL;
        end else if (sel_idcode && shift_dr) begin
            idcode_d = {jtag.tdi, idcode_q[31:1]};
        end
    end

    always_ff @(posedge tck) begin
        if (!trst) begin
            ir_shift_q <= '0;
            ir_q       <= OP_IDCODE;
            bypass_q   <= 1'b0;
            idcode_q   <= '0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_q       <= ir_d;
            bypass_q   <= bypass_d;
            idcode_q   <= idcode_d;
        end
    end

    for (genvar gi = 0; gi < NUM_DR; gi++) begin : g_user
        logic [DR_WIDTH-1:0] shift_q, shift_d;
        logic [DR_WIDTH-1:0] upd_q, upd_d;
        logic                pulse_q, pulse_d;

        assign sel_user[gi] = (ir_q == IR_WIDTH'(gi + 2));

        always_comb begin
            shift_d = shift_q;
            upd_d   = upd_q;
            pulse_d = 1'b0;
            if (sel_user[gi] && cap_dr) begin
                shift_d = dr_cap_data[gi*DR_WIDTH +: DR_WIDTH];
            end else if (sel_user[gi] && shift_dr) begin
                shift_d = DR_WIDTH'({jtag.tdi, shift_q} >> 1);
            end
            if (sel_user[gi] && upd_dr) begin
                upd_d   = shift_q;
                pulse_d = 1'b1;
            end
        end

        always_ff @(posedge tck) begin
            if (!trst) begin
                shift_q <= '0;
                upd_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                shift_q <= shift_d;
                upd_q   <= upd_d;
                pulse_q <= pulse_d;
            end
        end

        assign user_lsb[gi]                           = shift_q[0];
        assign dr_upd_data[gi*DR_WIDTH +: DR_WIDTH]   = upd_q;
        assign dr_upd_pulse[gi]                       = pulse_q;
    end

    assign jtag.tdo_en = (state == TAP_SHIFT_DR) || (state == TAP_SHIFT_IR);

    always_comb begin
        jtag.tdo = 1'b0;
        if (state == TAP_SHIFT_IR) begin
            jtag.tdo = ir_shift_q[0];
        end else if (state == TAP_SHIFT_DR) begin
            if (sel_idcode) begin
                jtag.tdo = idcode_q[0];
            end else if (sel_bypass) begin
                jtag.tdo = bypass_q;
            end else begin
                jtag.tdo = |(user_lsb & sel_user);
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IDCODE, BYPASS, USER capture/update, IR capture,
// spare-code decode, PAUSE resume and reset abort.
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    logic        tck;
    logic        trst;
    logic [3:0]  ir_q;
    logic [31:0] dr_cap_data;
    logic [31:0] dr_upd_data;
    logic [1:0]  dr_upd_pulse;
    int          total;
    int          bad;

    jtag_if jif ();

    jtag_tap_ctrl #(
        .IR_WIDTH   (4),
        .DR_WIDTH   (16),
        .NUM_DR     (2),
        .IDCODE_VAL (32'h1000_0001)
    ) dut (
        .tck          (tck),
        .trst         (trst),
        .jtag         (jif),
        .ir_q         (ir_q),
        .dr_cap_data  (dr_cap_data),
        .dr_upd_data  (dr_upd_data),
        .dr_upd_pulse (dr_upd_pulse)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            $display("[%0t] %s observed=0x%0h expected=0x%0h ok", $time, tag, obs, exp);
        end else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive tms/tdi, sample tdo just before the rising edge, return 1 ns after it.
    task automatic step(input logic t, input logic d, output logic o);
        jif.tms = t;
        jif.tdi = d;
        @(negedge tck);
        o = jif.tdo;
        @(posedge tck);
        #1;
    endtask

    task automatic shift(input logic [31:0] din, input int n, input bit do_exit,
                         output logic [31:0] dout);
        logic o;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            step(do_exit && (i == n - 1), din[i], o);
            dout[i] = o;
        end
    endtask

    task automatic goto_shift_dr();
        logic o;
        step(1'b1, 1'b0, o);
        step(1'b0, 1'b0, o);
        step(1'b0, 1'b0, o);
    endtask

    task automatic exit_to_rti();
        logic o;
        step(1'b1, 1'b0, o);
        step(1'b0, 1'b0, o);
    endtask

    task automatic load_ir(input logic [3:0] val);
        logic        o;
        logic [31:0] dump;
        step(1'b1, 1'b0, o);
        step(1'b1, 1'b0, o);
        step(1'b0, 1'b0, o);
        step(1'b0, 1'b0, o);
        shift({28'd0, val}, 4, 1'b1, dump);
        exit_to_rti();
    endtask

    initial begin
        logic        o;
        logic [31:0] dout;
        total       = 0;
        bad         = 0;
        trst        = 1'b0;
        jif.tms     = 1'b0;
        jif.tdi     = 1'b0;
        dr_cap_data = 32'h0;

        // 1. reset held 2 cycles with tms=0, then five tms=1
        @(posedge tck); #1;
        @(posedge tck); #1;
        chk("rst_state", 32'(dut.u_fsm.state_q), 32'(TAP_TLR));
        chk("rst_ir", 32'(ir_q), 32'h1);
        chk("rst_upd_data", dr_upd_data, 32'h0);
        chk("rst_pulse", 32'(dr_upd_pulse), 32'h0);
        chk("rst_tdo_en", 32'(jif.tdo_en), 32'h0);
        trst = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, o);
        chk("tlr_state", 32'(dut.u_fsm.state_q), 32'(TAP_TLR));
        chk("tlr_ir", 32'(ir_q), 32'h1);

        // 2. IDCODE read
        step(1'b0, 1'b0, o);
        goto_shift_dr();
        chk("idc_tdo_en", 32'(jif.tdo_en), 32'h1);
        chk("idc_first_bit", 32'(jif.tdo), 32'h1);
        shift(32'h0, 32, 1'b1, dout);
        chk("idc_value", dout, 32'h1000_0001);
        exit_to_rti();
        chk("idc_upd_data", dr_upd_data, 32'h0);
        chk("idc_tdo_en_off", 32'(jif.tdo_en), 32'h0);

        // 3. BYPASS via all-ones
        load_ir(4'hF);
        chk("byp_ir", 32'(ir_q), 32'hF);
        goto_shift_dr();
        shift(32'h0A5, 9, 1'b1, dout);
        chk("byp_first_bit", 32'(dout[0]), 32'h0);
        chk("byp_data", dout, 32'h14A);
        exit_to_rti();

        // 4. USER_1 capture/update
        dr_cap_data = {16'hBEEF, 16'h5555};
        load_ir(4'h3);
        chk("u1_ir", 32'(ir_q), 32'h3);
        goto_shift_dr();
        shift(32'h1234, 16, 1'b1, dout);
        chk("u1_capture", dout, 32'hBEEF);
        step(1'b1, 1'b0, o);
        chk("u1_pulse_pre", 32'(dr_upd_pulse), 32'h0);
        step(1'b0, 1'b0, o);
        chk("u1_pulse", 32'(dr_upd_pulse), 32'h2);
        chk("u1_upd_data", dr_upd_data, 32'h1234_0000);
        step(1'b0, 1'b0, o);
        chk("u1_pulse_post", 32'(dr_upd_pulse), 32'h0);

        // 5. IR capture pattern and spare code 9 as BYPASS
        step(1'b1, 1'b0, o);
        step(1'b1, 1'b0, o);
        step(1'b0, 1'b0, o);
        step(1'b0, 1'b0, o);
        chk("ir_tdo_en", 32'(jif.tdo_en), 32'h1);
        shift(32'h9, 4, 1'b1, dout);
        chk("ir_capture", dout, 32'h1);
        chk("ir_no_mid_change", 32'(ir_q), 32'h3);
        exit_to_rti();
        chk("ir9", 32'(ir_q), 32'h9);
        goto_shift_dr();
        shift(32'h03C, 9, 1'b1, dout);
        chk("ir9_bypass", dout, 32'h078);
        exit_to_rti();
        chk("ir9_no_pulse", 32'(dr_upd_pulse), 32'h0);
        chk("ir9_upd_data", dr_upd_data, 32'h1234_0000);

        // 6. USER_0 with a PAUSE_DR excursion mid-shift
        dr_cap_data = {16'hBEEF, 16'hC0DE};
        load_ir(4'h2);
        goto_shift_dr();
        shift(32'h00F0, 8, 1'b1, dout);
        chk("u0_lo", dout, 32'h00DE);
        step(1'b0, 1'b1, o);
        step(1'b0, 1'b1, o);
        step(1'b0, 1'b1, o);
        step(1'b1, 1'b1, o);
        step(1'b0, 1'b1, o);
        chk("u0_resume_bit", 32'(jif.tdo), 32'h0);
        shift(32'h00A5, 8, 1'b1, dout);
        chk("u0_hi", dout, 32'h00C0);
        step(1'b1, 1'b0, o);
        step(1'b0, 1'b0, o);
        chk("u0_pulse", 32'(dr_upd_pulse), 32'h1);
        chk("u0_upd_data", dr_upd_data, 32'h1234_A5F0);

        // trst pulse aborts a USER_0 shift
        goto_shift_dr();
        shift(32'h001F, 5, 1'b0, dout);
        trst = 1'b0;
        step(1'b0, 1'b0, o);
        chk("abort_upd_data", dr_upd_data, 32'h0);
        chk("abort_pulse", 32'(dr_upd_pulse), 32'h0);
        chk("abort_tdo_en", 32'(jif.tdo_en), 32'h0);
        chk("abort_ir", 32'(ir_q), 32'h1);
        trst = 1'b1;
        step(1'b1, 1'b0, o);
        step(1'b1, 1'b0, o);
        chk("abort_state", 32'(dut.u_fsm.state_q), 32'(TAP_TLR));
        chk("abort_no_pulse", 32'(dr_upd_pulse), 32'h0);
        chk("abort_data_held", dr_upd_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
